// File: rtl/mem_port_arbiter.sv
// Two-source arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins by default; a bounded starvation counter forces a fetch through, and a wait timer ends hung grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_mem_ack,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_mem_ack,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, INST, DATA, DONE} state_e;

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]      TIMEOUT_W  = 8'(TIMEOUT);

  state_e        state_q;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    wait_q, wait_d;
  logic          src_data_q;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   inst_rdata_q, data_rdata_q;
  logic          bus_err_q;
  logic          data_wins;
  logic          timeout_hit;

  always_comb begin
    data_wins   = data_req && !(inst_req && (starve_q == STARVE_MAX));
    wait_d      = wait_q + 8'd1;
    timeout_hit = (wait_d == TIMEOUT_W);
    // Starvation credit only accrues while a fetch is actually waiting.
    starve_d    = '0;
    if (inst_req) starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      wait_q       <= '0;
      src_data_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (data_wins) begin
            state_q    <= DATA;
            src_data_q <= 1'b1;
            we_q       <= data_we;
            addr_q     <= data_addr;
            wdata_q    <= data_wdata;
            be_q       <= data_be;
            starve_q   <= starve_d;
          end else if (inst_req) begin
            state_q    <= INST;
            src_data_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= inst_addr;
            wdata_q    <= '0;
            be_q       <= 4'b1111;
            starve_q   <= '0;
          end else begin
            starve_q   <= '0;
          end
        end
        INST, DATA: begin
          if (mem_ready) begin
            state_q <= DONE;
            if (!src_data_q)  inst_rdata_q <= mem_rdata;
            else if (!we_q)   data_rdata_q <= mem_rdata;
          end else if (timeout_hit) begin
            // A hung access completes with zero read data and an error flag.
            state_q   <= DONE;
            bus_err_q <= 1'b1;
            if (!src_data_q)  inst_rdata_q <= '0;
            else if (!we_q)   data_rdata_q <= '0;
          end else begin
            wait_q <= wait_d;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          bus_err_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req      = (state_q == INST) || (state_q == DATA);
  assign mem_we       = (state_q == DATA) && we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_be       = be_q;
  assign inst_mem_ack = (state_q == DONE) && !src_data_q;
  assign data_mem_ack = (state_q == DONE) && src_data_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign bus_err      = bus_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation, store, timeout and reset abort.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_mem_ack;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_mem_ack;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_mem_ack(inst_mem_ack), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be),
    .data_mem_ack(data_mem_ack), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req"},   32'(mem_req),      32'd0);
    check({tag, " mem_we"},    32'(mem_we),       32'd0);
    check({tag, " mem_addr"},  mem_addr,          32'd0);
    check({tag, " mem_wdata"}, mem_wdata,         32'd0);
    check({tag, " mem_be"},    32'(mem_be),       32'd0);
    check({tag, " i_ack"},     32'(inst_mem_ack), 32'd0);
    check({tag, " d_ack"},     32'(data_mem_ack), 32'd0);
    check({tag, " bus_err"},   32'(bus_err),      32'd0);
    check({tag, " busy"},      32'(busy),         32'd0);
    check({tag, " i_rdata"},   inst_rdata,        32'd0);
    check({tag, " d_rdata"},   data_rdata,        32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] exp_addr;
    logic        exp_data;

    reset = 1'b1; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Single fetch: minimum 3-cycle latency.
    inst_req = 1'b1; inst_addr = 32'h100;
    check("fetch c0 busy", 32'(busy), 32'd0);
    tick();
    check("fetch c1 mem_req", 32'(mem_req), 32'd1);
    check("fetch c1 mem_addr", mem_addr, 32'h100);
    check("fetch c1 mem_we", 32'(mem_we), 32'd0);
    check("fetch c1 mem_be", 32'(mem_be), 32'hF);
    mem_ready = 1'b1; mem_rdata = 32'h2402000A;
    tick();
    check("fetch c2 i_ack", 32'(inst_mem_ack), 32'd1);
    check("fetch c2 d_ack", 32'(data_mem_ack), 32'd0);
    check("fetch c2 i_rdata", inst_rdata, 32'h2402000A);
    check("fetch c2 mem_req", 32'(mem_req), 32'd0);
    check("fetch c2 bus_err", 32'(bus_err), 32'd0);
    inst_req = 1'b0;
    tick();
    check("fetch c3 i_ack", 32'(inst_mem_ack), 32'd0);
    check("fetch c3 busy", 32'(busy), 32'd0);

    // Simultaneous requests: data first, then fetch; mem_ready stays high through IDLE/DONE.
    inst_req = 1'b1; inst_addr = 32'h104;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h2000; data_be = 4'hF;
    mem_rdata = 32'h11112222;
    tick();
    check("sim data grant addr", mem_addr, 32'h2000);
    check("sim data grant we", 32'(mem_we), 32'd0);
    tick();
    check("sim d_ack", 32'(data_mem_ack), 32'd1);
    check("sim i_ack low", 32'(inst_mem_ack), 32'd0);
    check("sim d_rdata", data_rdata, 32'h11112222);
    data_req = 1'b0; mem_rdata = 32'h33334444;
    tick();
    check("sim idle mem_req", 32'(mem_req), 32'd0);
    check("sim idle d_ack", 32'(data_mem_ack), 32'd0);
    tick();
    check("sim inst grant addr", mem_addr, 32'h104);
    check("sim inst grant be", 32'(mem_be), 32'hF);
    tick();
    check("sim i_ack", 32'(inst_mem_ack), 32'd1);
    check("sim d_ack low", 32'(data_mem_ack), 32'd0);
    check("sim i_rdata", inst_rdata, 32'h33334444);
    check("sim d_rdata held", data_rdata, 32'h11112222);
    inst_req = 1'b0;
    tick();

    // Starvation: 4 data grants, then the fetch, then data resumes.
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h3000;
    inst_req = 1'b1; inst_addr = 32'h200;
    mem_rdata = 32'h55556666;
    for (int g = 0; g < 6; g++) begin
      exp_data = (g != 4);
      exp_addr = exp_data ? 32'h3000 : 32'h200;
      check($sformatf("starve g%0d idle", g), 32'(busy), 32'd0);
      tick();
      check($sformatf("starve g%0d addr", g), mem_addr, exp_addr);
      tick();
      check($sformatf("starve g%0d d_ack", g), 32'(data_mem_ack), 32'(exp_data));
      check($sformatf("starve g%0d i_ack", g), 32'(inst_mem_ack), 32'(!exp_data));
      if (!exp_data) inst_req = 1'b0;
      tick();
    end
    data_req = 1'b0;
    check("starve d_rdata", data_rdata, 32'h55556666);

    // Store with 5 wait cycles; live inputs change to prove outputs come from latches.
    mem_ready = 1'b0; mem_rdata = 32'h99999999;
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
    data_addr = 32'h4000; data_wdata = 32'hDEADBEEF;
    tick();
    data_addr = 32'hFFFF_FFFF; data_wdata = 32'h0; data_be = 4'hF; data_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("store c%0d req", i), 32'(mem_req), 32'd1);
      check($sformatf("store c%0d we", i), 32'(mem_we), 32'd1);
      check($sformatf("store c%0d addr", i), mem_addr, 32'h4000);
      check($sformatf("store c%0d wdata", i), mem_wdata, 32'hDEADBEEF);
      check($sformatf("store c%0d be", i), 32'(mem_be), 32'h3);
      if (i == 5) mem_ready = 1'b1;
      tick();
    end
    check("store d_ack", 32'(data_mem_ack), 32'd1);
    check("store bus_err", 32'(bus_err), 32'd0);
    check("store d_rdata kept", data_rdata, 32'h55556666);
    data_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("store idle we", 32'(mem_we), 32'd0);
    check("store idle d_ack", 32'(data_mem_ack), 32'd0);

    // Timeout: mem_ready never comes.
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h5000; data_be = 4'hF;
    tick();
    n = 0;
    while (mem_req && n < 400) begin
      n++;
      tick();
    end
    check("timeout grant cycles", 32'(n), 32'd255);
    check("timeout d_ack", 32'(data_mem_ack), 32'd1);
    check("timeout bus_err", 32'(bus_err), 32'd1);
    check("timeout d_rdata", data_rdata, 32'd0);
    data_req = 1'b0;
    tick();
    check("timeout bus_err clear", 32'(bus_err), 32'd0);

    // Reset mid-DATA: no ack, all outputs zero, then a fresh grant.
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h6000;
    tick();
    check("rst pre mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    check_all_zero("rst mid");
    reset = 1'b0;
    tick();
    check("rst regrant req", 32'(mem_req), 32'd1);
    check("rst regrant addr", mem_addr, 32'h6000);
    mem_ready = 1'b1; mem_rdata = 32'hABCD0123;
    tick();
    check("rst regrant d_ack", 32'(data_mem_ack), 32'd1);
    check("rst regrant i_ack", 32'(inst_mem_ack), 32'd0);
    check("rst regrant d_rdata", data_rdata, 32'hABCD0123);
    data_req = 1'b0; mem_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
